ntsc_zbt_reader: RTL and testbench
==================================

# ntsc_zbt_reader

Display-side reader for the NTSC frame buffer held in ZBT RAM. Maps the XVGA raster position (`hcount`/`vcount`) onto the frame-buffer address layout used by the NTSC write path: one 30-bit pixel per 36-bit word, address `{line[8:0], col[9:0]}`, where `line = 2*field_row + even_odd`. It issues pipelined reads, absorbs the fixed ZBT read latency, and presents pixels with delayed syncs so pixel and sync outputs stay aligned. It also owns a frame-aligned write-inhibit that lets the display freeze a captured frame without tearing.

## Interface
Parameters:
- `H_START`, 11'd0: first display column of the video window.
- `V_START`, 10'd0: first display line of the video window.
- `WIDTH`, 11'd640: window width in pixels (≤1024).
- `HEIGHT`, 10'd480: window height in lines (≤512).
- `LATENCY`, 2: clk cycles from `vram_addr`/`vram_re` registered to valid `vram_read_data`.

Ports:
- `clk` in 1: system/pixel clock. Sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `hcount` in 11: raster column from the XVGA timing generator.
- `vcount` in 10: raster line.
- `hsync`, `vsync` in 1 each: active-low syncs.
- `blank` in 1: active-high blanking.
- `freeze` in 1: request to hold the current frame. Level, sampled only at frame start.
- `vram_read_data` in 36: ZBT read data. Bits [29:0] are the pixel; [35:30] are ignored.
- `vram_addr` out 19: ZBT read address.
- `vram_re` out 1: read request for this cycle.
- `pixel` out 30: pixel aligned to the delayed syncs.
- `pixel_valid` out 1: `pixel` lies inside the window.
- `hsync_out`, `vsync_out`, `blank_out` out 1 each: inputs delayed by D = LATENCY+2.
- `write_inhibit` out 1: gate for the NTSC writer's write enable. 1 means suppress writes.
- `frame_count` out 8: frames seen since leaving WAIT_SYNC.

## Operation
- Frame start (FS): a cycle where `vsync`=0 and the registered previous `vsync`=1.
- Window: `in_win = (hcount-H_START) < WIDTH && (vcount-V_START) < HEIGHT`. Compare unsigned; negative differences wrap large, so they fall outside the window.
- Address: `col = hcount-H_START` (low 10 bits), `line = vcount-V_START` (low 9 bits), `vram_addr = {line, col}`.
- State machine, 2-bit state:
  - WAIT_SYNC: reset state. `vram_re`=0 and `pixel_valid`=0. On FS go to RUN, or to HOLD if `freeze`=1.
  - RUN: reads enabled, `write_inhibit`=0. On FS with `freeze`=1 go to HOLD.
  - HOLD: reads enabled, `write_inhibit`=1. On FS with `freeze`=0 go to RUN.
- State changes and `write_inhibit` changes happen only at FS. `freeze` toggles mid-frame have no effect until the next FS.
- `frame_count` increments on every FS outside WAIT_SYNC, and on the FS that exits WAIT_SYNC. It wraps 255→0.
- Outside the window, or in WAIT_SYNC: `vram_re`=0, `vram_addr` holds its last value, and the aligned `pixel`=0 with `pixel_valid`=0.
- A shift register of depth LATENCY+1 carries the `in_win` flag alongside each request. `pixel` captures `vram_read_data[29:0]` only when the flag arriving with that data is 1; otherwise `pixel` is 0.

## Timing
- Cycle t: raster (h,v) presented.
- t+1: `vram_addr`/`vram_re` registered.
- t+1+LATENCY: data valid on `vram_read_data`.
- t+2+LATENCY: `pixel`/`pixel_valid` registered.
- Sync/blank delay chain length is D = LATENCY+2, so `hsync_out`/`vsync_out`/`blank_out` at t+D correspond to the pixel for (h,v).
- FS detection adds 1 cycle. The state and `write_inhibit` update at t+1 after the FS cycle t.
- Reset values, applied asynchronously:
  - `vram_addr`=0, `vram_re`=0, `pixel`=0, `pixel_valid`=0.
  - `hsync_out`=1, `vsync_out`=1, `blank_out`=1.
  - `write_inhibit`=0, `frame_count`=0.
  - state = WAIT_SYNC; all delay chains flushed to their idle values.
- Reset mid-frame: in-flight reads are discarded (valid flags cleared). Output stays idle until the next FS after `reset_n` rises.
- Window edges:
  - `hcount`=H_START+WIDTH-1 is the last read of a line.
  - `hcount`=H_START+WIDTH issues no read.
  - `vcount`=V_START+HEIGHT-1 is the last line.
- Back-to-back in-window cycles issue one read per clk. No bubbles.

## Test plan
- Reset, then 1024×768 raster with LATENCY=2 and memory model word[a]=a: first FS→RUN. At (h=5,v=3), `vram_addr`=0x00C05 at t+1, and `pixel`=0x00C05 with `pixel_valid`=1 at t+4, aligned with delayed `blank_out`=0.
- H_START=100, V_START=50: (99,50) → `vram_re`=0, `pixel_valid`=0. (100,50) → addr 0. (739,50) → addr 0x0027F. (740,50) → no read.
- `freeze` 0→1 mid-frame: `write_inhibit` stays 0 until the next FS, then goes to 1 one cycle after FS. `freeze`→0 clears it only at the following FS.
- No FS after reset: `vram_re` never asserts, `pixel`=0, `frame_count`=0. After 257 FS, `frame_count`=1 (wrap).
- Assert `reset_n`=0 mid-line with reads in flight: all outputs take their reset values immediately. After release, no `pixel_valid` until the next FS.
- LATENCY=3: delayed syncs and `pixel` remain aligned, with pixel at t+5.

Source files
------------

// File: rtl/ntsc_zbt_reader.sv
// ============================================================================
// ntsc_zbt_reader
// ----------------------------------------------------------------------------
// Display-side reader for the NTSC frame buffer stored in ZBT RAM.
//
// The XVGA raster position (hcount/vcount) is translated into the address
// layout used by the NTSC write path: one 30-bit pixel per 36-bit word at
// address {line[8:0], col[9:0]}, relative to the top-left corner of the
// video window (H_START, V_START).  Reads are issued one per clock while the
// raster is inside the window.  The fixed ZBT read latency is absorbed by a
// valid-flag pipeline, and the incoming syncs/blank are delayed by the same
// total amount so pixel and sync outputs stay aligned.
//
// The block also owns a frame-aligned write inhibit: a freeze request is
// only honoured at frame start, so the NTSC writer is never stopped (or
// restarted) half-way through a frame and the held picture cannot tear.
//
// Ports
//   clk             pixel/system clock (only clock)
//   reset_n         asynchronous active-low reset
//   hcount, vcount  raster column / line from the XVGA timing generator
//   hsync, vsync    active-low syncs from the timing generator
//   blank           active-high blanking from the timing generator
//   freeze          level request to hold the current frame (frame start only)
//   vram_read_data  ZBT read data; [29:0] pixel, [35:30] unused
//   vram_addr       ZBT read address
//   vram_re         read request for this cycle
//   pixel           pixel aligned with the delayed syncs (0 outside window)
//   pixel_valid     pixel lies inside the video window
//   hsync_out, vsync_out, blank_out
//                   timing inputs delayed by LATENCY+2 clocks
//   write_inhibit   1 = NTSC writer must suppress writes (frame held)
//   frame_count     frames seen since leaving WAIT_SYNC (wraps 255 -> 0)
// ============================================================================
module ntsc_zbt_reader #(
    parameter logic [10:0] H_START = 11'd0,
    parameter logic [9:0]  V_START = 10'd0,
    parameter logic [10:0] WIDTH   = 11'd640,
    parameter logic [9:0]  HEIGHT  = 10'd480,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic        freeze,
    input  logic [35:0] vram_read_data,
    output logic [18:0] vram_addr,
    output logic        vram_re,
    output logic [29:0] pixel,
    output logic        pixel_valid,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic        write_inhibit,
    output logic [7:0]  frame_count
);

    // Total pipeline depth from raster input to registered pixel output.
    localparam int D = LATENCY + 2;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        RUN       = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic        vsync_prev;
    logic        frame_start;
    logic [10:0] h_off;
    logic [9:0]  v_off;
    logic        in_win;
    logic        read_en;

    // win_pipe[k] carries the in-window flag of the request issued k+1
    // clocks ago; index LATENCY lines up with the returning ZBT data.
    logic [LATENCY:0] win_pipe;

    logic [D-1:0] hsync_pipe;
    logic [D-1:0] vsync_pipe;
    logic [D-1:0] blank_pipe;

    // Tag bits of the ZBT word are not part of the pixel.
    logic [5:0] unused_tag;
    assign unused_tag = vram_read_data[35:30];

    // ------------------------------------------------------------------------
    // Frame start is the falling edge of the active-low vsync.  The previous
    // value resets to 0 so that coming out of reset while vsync is already
    // low is not mistaken for a frame start; a genuine high-to-low edge is
    // needed before the reader leaves WAIT_SYNC.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync;
        end
    end

    assign frame_start = ~vsync & vsync_prev;

    // ------------------------------------------------------------------------
    // Window test and relative coordinates.  The subtraction is unsigned, so
    // positions left of / above the window wrap to large values and fail the
    // compare without needing a separate lower-bound test.
    // ------------------------------------------------------------------------
    assign h_off  = hcount - H_START;
    assign v_off  = vcount - V_START;
    assign in_win = (h_off < WIDTH) && (v_off < HEIGHT);

    // ------------------------------------------------------------------------
    // Mode state register.  write_inhibit is registered from the next state
    // so it changes on exactly the same edge as the state and is glitch-free
    // when it gates the writer's write enable.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_SYNC;
            write_inhibit <= 1'b0;
        end else begin
            state         <= state_next;
            write_inhibit <= (state_next == HOLD);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and read-enable decode.  Mode changes are only evaluated on
    // frame start, so freeze is effectively sampled once per frame.  Reads
    // stay enabled in HOLD: the display keeps showing the held frame, only
    // the writer is stopped.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        read_en    = 1'b0;
        case (state)
            WAIT_SYNC: begin
                if (frame_start) begin
                    state_next = freeze ? HOLD : RUN;
                end
            end
            RUN: begin
                read_en = in_win;
                if (frame_start && freeze) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                read_en = in_win;
                if (frame_start && !freeze) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = WAIT_SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame counter.  Every frame start counts: in WAIT_SYNC a frame start is
    // by definition the one that leaves WAIT_SYNC, and in RUN/HOLD all of
    // them count.  Natural 8-bit wrap.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 8'd0;
        end else if (frame_start) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Read request register.  The address only updates on an actual read so
    // the ZBT address bus stays quiet outside the window.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr <= 19'd0;
            vram_re   <= 1'b0;
        end else begin
            vram_re <= read_en;
            if (read_en) begin
                vram_addr <= {v_off[8:0], h_off[9:0]};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Valid-flag pipeline travelling alongside the read requests.  Reset
    // clears it, which discards any reads still in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_pipe <= '0;
        end else begin
            win_pipe <= {win_pipe[LATENCY-1:0], read_en};
        end
    end

    // ------------------------------------------------------------------------
    // Output pixel register.  Data is only captured when the flag that
    // travelled with the request says it belongs to the window; otherwise the
    // output is forced to black so stale bus values never reach the display.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel       <= 30'd0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= win_pipe[LATENCY];
            pixel       <= win_pipe[LATENCY] ? vram_read_data[29:0] : 30'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Sync and blank delay lines, D stages long so their outputs line up with
    // the registered pixel.  They flush to the idle (inactive sync, blanked)
    // level on reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_pipe <= '1;
            vsync_pipe <= '1;
            blank_pipe <= '1;
        end else begin
            hsync_pipe <= {hsync_pipe[D-2:0], hsync};
            vsync_pipe <= {vsync_pipe[D-2:0], vsync};
            blank_pipe <= {blank_pipe[D-2:0], blank};
        end
    end

    assign hsync_out = hsync_pipe[D-1];
    assign vsync_out = vsync_pipe[D-1];
    assign blank_out = blank_pipe[D-1];

endmodule

// File: tb/tb_ntsc_zbt_reader.sv
// ============================================================================
// tb_ntsc_zbt_reader
// ----------------------------------------------------------------------------
// Scoreboard bench for ntsc_zbt_reader.  Two instances share the raster
// inputs: one with LATENCY=2 and one with LATENCY=3, both with the window at
// (100,50) size 640x480.  Each has a ZBT model returning word[a] = a (with a
// non-zero tag in [35:30]).  Stimulus pushes the expected pixel, syncs and
// arrival cycle into a per-instance queue; a monitor pops and compares every
// cycle.  Directed checks cover reset values, window edges, freeze timing,
// mid-line reset and frame counter wrap.
// ============================================================================
module tb_ntsc_zbt_reader;

    localparam logic [10:0] H_START = 11'd100;
    localparam logic [9:0]  V_START = 10'd50;
    localparam logic [10:0] WIDTH   = 11'd640;
    localparam logic [9:0]  HEIGHT  = 10'd480;
    localparam int          LAT_A   = 2;
    localparam int          LAT_B   = 3;

    typedef struct {
        int          due;
        logic [29:0] pix;
        logic        hs;
        logic        vs;
        logic        bl;
    } sb_entry_t;

    logic        clk;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        freeze;

    logic [35:0] rdataA, rdataB;
    logic [18:0] addrA, addrB;
    logic        reA, reB;
    logic [29:0] pixA, pixB;
    logic        validA, validB;
    logic        hsA, hsB, vsA, vsB, blA, blB;
    logic        wiA, wiB;
    logic [7:0]  fcA, fcB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prevVs = 1'b0;
    logic modelActive = 1'b0;
    logic sawRe = 1'b0;

    sb_entry_t qA[$];
    sb_entry_t qB[$];

    logic [18:0] memA [LAT_A];
    logic [18:0] memB [LAT_B];

    ntsc_zbt_reader #(
        .H_START(H_START), .V_START(V_START), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LATENCY(LAT_A)
    ) dutA (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .freeze(freeze),
        .vram_read_data(rdataA), .vram_addr(addrA), .vram_re(reA),
        .pixel(pixA), .pixel_valid(validA), .hsync_out(hsA), .vsync_out(vsA),
        .blank_out(blA), .write_inhibit(wiA), .frame_count(fcA)
    );

    ntsc_zbt_reader #(
        .H_START(H_START), .V_START(V_START), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LATENCY(LAT_B)
    ) dutB (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .freeze(freeze),
        .vram_read_data(rdataB), .vram_addr(addrB), .vram_re(reB),
        .pixel(pixB), .pixel_valid(validB), .hsync_out(hsB), .vsync_out(vsB),
        .blank_out(blB), .write_inhibit(wiB), .frame_count(fcB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ZBT models: the address registered by the DUT comes back LATENCY clocks
    // later as data, with a tag in the upper bits that must be ignored.
    always @(posedge clk) begin
        memA[0] <= addrA;
        for (int i = 1; i < LAT_A; i++) memA[i] <= memA[i-1];
        memB[0] <= addrB;
        for (int j = 1; j < LAT_B; j++) memB[j] <= memB[j-1];
    end
    assign rdataA = {6'h2A, 11'd0, memA[LAT_A-1]};
    assign rdataB = {6'h15, 11'd0, memB[LAT_B-1]};

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic checkOutput(input string name, input logic hasE, input sb_entry_t e,
                               input logic [29:0] pix, input logic val,
                               input logic hs, input logic vs, input logic bl);
        checks++;
        if (hasE) begin
            if (val !== 1'b1 || pix !== e.pix || hs !== e.hs || vs !== e.vs || bl !== e.bl || e.due != cyc) begin
                errors++;
                $display("[TB] FAIL %s pixel: got valid=%b pix=0x%0h hs=%b vs=%b bl=%b cycle=%0d, expected valid=1 pix=0x%0h hs=%b vs=%b bl=%b cycle=%0d",
                         name, val, pix, hs, vs, bl, cyc, e.pix, e.hs, e.vs, e.bl, e.due);
            end
        end else if (val !== 1'b0 || pix !== 30'd0) begin
            errors++;
            $display("[TB] FAIL %s idle: got valid=%b pix=0x%0h, expected valid=0 pix=0x0 (cycle %0d)",
                     name, val, pix, cyc);
        end
    endtask

    // Monitor: an entry is consumed when the DUT presents a pixel or when the
    // entry's arrival cycle has been reached, so late, early, missing and
    // unexpected pixels all show up as mismatches.
    initial begin
        sb_entry_t e;
        logic hasE;
        forever begin
            @(posedge clk);
            #1;
            e = '{due: 0, pix: 30'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1};
            hasE = (qA.size() > 0) && (validA === 1'b1 || qA[0].due <= cyc);
            if (hasE) e = qA.pop_front();
            checkOutput("A", hasE, e, pixA, validA, hsA, vsA, blA);
            e = '{due: 0, pix: 30'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1};
            hasE = (qB.size() > 0) && (validB === 1'b1 || qB[0].due <= cyc);
            if (hasE) e = qB.pop_front();
            checkOutput("B", hasE, e, pixB, validB, hsB, vsB, blB);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reA === 1'b1) sawRe = 1'b1;
        end
    end

    // Drives one raster cycle and records what the DUTs must produce for it.
    task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v,
                                 input logic hs, input logic vs, input logic bl);
        sb_entry_t e;
        logic [10:0] ho;
        logic [9:0]  vo;
        logic        fs;
        @(negedge clk);
        hcount = h;
        vcount = v;
        hsync  = hs;
        vsync  = vs;
        blank  = bl;
        ho = h - H_START;
        vo = v - V_START;
        fs = !vs && prevVs;
        if (modelActive && ho < WIDTH && vo < HEIGHT) begin
            e.pix = {11'd0, vo[8:0], ho[9:0]};
            e.hs  = hs;
            e.vs  = vs;
            e.bl  = bl;
            e.due = cyc + LAT_A + 2;
            qA.push_back(e);
            e.due = cyc + LAT_B + 2;
            qB.push_back(e);
        end
        if (fs) modelActive = 1'b1;
        prevVs = vs;
    endtask

    task automatic drivePix(input logic [10:0] h, input logic [9:0] v);
        logic [10:0] ho;
        logic [9:0]  vo;
        ho = h - H_START;
        vo = v - V_START;
        applyStimulus(h, v, ~h[1], 1'b1, !(ho < WIDTH && vo < HEIGHT));
    endtask

    task automatic checkRead(input logic [10:0] h, input logic [9:0] v,
                             input logic expRe, input logic [18:0] expAddr);
        drivePix(h, v);
        @(posedge clk);
        #1;
        checkVal($sformatf("re(%0d,%0d)", h, v), {31'd0, reA}, {31'd0, expRe});
        checkVal($sformatf("addr(%0d,%0d)", h, v), {13'd0, addrA}, {13'd0, expAddr});
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, " vram_addr"}, {13'd0, addrA}, 32'd0);
        checkVal({tag, " vram_re"}, {31'd0, reA}, 32'd0);
        checkVal({tag, " pixel"}, {2'd0, pixA}, 32'd0);
        checkVal({tag, " pixel_valid"}, {31'd0, validA}, 32'd0);
        checkVal({tag, " hsync_out"}, {31'd0, hsA}, 32'd1);
        checkVal({tag, " vsync_out"}, {31'd0, vsA}, 32'd1);
        checkVal({tag, " blank_out"}, {31'd0, blA}, 32'd1);
        checkVal({tag, " write_inhibit"}, {31'd0, wiA}, 32'd0);
        checkVal({tag, " frame_count"}, {24'd0, fcA}, 32'd0);
        checkVal({tag, " B pixel_valid"}, {31'd0, validB}, 32'd0);
    endtask

    task automatic frameStart();
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        hcount  = 11'd0;
        vcount  = 10'd0;
        hsync   = 1'b1;
        vsync   = 1'b1;
        blank   = 1'b1;
        freeze  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // No frame start yet: in-window raster must not produce reads.
        sawRe = 1'b0;
        for (int h = 98; h <= 110; h++) drivePix(h[10:0], 10'd53);
        @(posedge clk);
        #1;
        checkVal("no-FS vram_re seen", {31'd0, sawRe}, 32'd0);
        checkVal("no-FS frame_count", {24'd0, fcA}, 32'd0);

        // First frame start -> RUN.
        frameStart();
        @(posedge clk);
        #1;
        checkVal("first FS frame_count", {24'd0, fcA}, 32'd1);
        checkVal("first FS write_inhibit", {31'd0, wiA}, 32'd0);

        // Window edges and addressing.
        checkRead(11'd99,  10'd50,  1'b0, 19'h00000);
        checkRead(11'd100, 10'd50,  1'b1, 19'h00000);
        checkRead(11'd101, 10'd50,  1'b1, 19'h00001);
        checkRead(11'd739, 10'd50,  1'b1, 19'h0027F);
        checkRead(11'd740, 10'd50,  1'b0, 19'h0027F);
        checkRead(11'd105, 10'd53,  1'b1, 19'h00C05);
        checkRead(11'd100, 10'd49,  1'b0, 19'h00C05);
        checkRead(11'd100, 10'd529, 1'b1, 19'h77C00);
        checkRead(11'd100, 10'd530, 1'b0, 19'h77C00);

        // Back-to-back reads across the left edge of a line.
        for (int h = 96; h <= 131; h++) drivePix(h[10:0], 10'd51);
        for (int h = 736; h <= 742; h++) drivePix(h[10:0], 10'd51);

        // Freeze: request mid-frame, honoured one cycle after the next FS.
        freeze = 1'b1;
        for (int h = 200; h <= 205; h++) drivePix(h[10:0], 10'd60);
        @(posedge clk);
        #1;
        checkVal("freeze mid-frame write_inhibit", {31'd0, wiA}, 32'd0);
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b0, 1'b1);
        #1;
        checkVal("freeze at FS write_inhibit", {31'd0, wiA}, 32'd0);
        @(posedge clk);
        #1;
        checkVal("freeze after FS write_inhibit", {31'd0, wiA}, 32'd1);
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        freeze = 1'b0;
        for (int h = 300; h <= 305; h++) drivePix(h[10:0], 10'd61);
        @(posedge clk);
        #1;
        checkVal("unfreeze mid-frame write_inhibit", {31'd0, wiA}, 32'd1);
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkVal("unfreeze after FS write_inhibit", {31'd0, wiA}, 32'd0);
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        checkVal("frame_count after 3 FS", {24'd0, fcA}, 32'd3);

        // Reset mid-line with reads in flight.
        for (int h = 400; h <= 410; h++) drivePix(h[10:0], 10'd70);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        qA.delete();
        qB.delete();
        modelActive = 1'b0;
        prevVs = 1'b0;
        #1;
        checkResetValues("mid-line reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int h = 400; h <= 420; h++) drivePix(h[10:0], 10'd71);
        @(posedge clk);
        #1;
        checkVal("post-reset vram_re", {31'd0, reA}, 32'd0);

        // 257 frame starts from WAIT_SYNC: counter wraps to 1.
        for (int i = 0; i < 257; i++) frameStart();
        @(posedge clk);
        #1;
        checkVal("frame_count wrap", {24'd0, fcA}, 32'd1);
        checkVal("B frame_count wrap", {24'd0, fcB}, 32'd1);

        // A final burst after the wrap, then drain.
        for (int h = 100; h <= 110; h++) drivePix(h[10:0], 10'd52);
        for (int i = 0; i < LAT_B + 4; i++) drivePix(11'd0, 10'd0);
        @(posedge clk);
        #2;
        checkVal("A scoreboard drained", qA.size(), 32'd0);
        checkVal("B scoreboard drained", qB.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
